// File: rtl/spi_slave_if.sv
// SPI mode-0 slave (MSB first) oversampled on the fabric clock; strobes received words and transmit requests.
// Optional MISO_TRISTATE_EN: miso floats while deselected or in reset instead of driving 0.
module spi_slave_if #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sck,
  input  logic             mosi,
  output logic             miso,
  input  logic             ssel,
  output logic             byte_received,
  output logic [WIDTH-1:0] received_data,
  output logic             data_needed,
  input  logic [WIDTH-1:0] data_to_send
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  // Two synchronizer stages, plus a third on sck/ssel for edge detection.
  logic [2:0] sck_reg;
  logic [2:0] ssel_reg;
  logic [1:0] mosi_reg;

  logic [CW-1:0]    bit_cnt_reg, bit_cnt_next;
  logic [WIDTH-1:0] rx_reg, rx_next;
  logic [WIDTH-1:0] tx_reg, tx_next;
  logic [WIDTH-1:0] received_data_reg, received_data_next;
  logic             byte_received_reg, byte_received_next;
  logic             data_needed_reg, data_needed_next;

  logic sck_rise;
  logic sck_fall;
  logic ssel_fall;
  logic active;
  logic mosi_bit;

  assign sck_rise  = sck_reg[1] & ~sck_reg[2];
  assign sck_fall  = ~sck_reg[1] & sck_reg[2];
  assign ssel_fall = ~ssel_reg[1] & ssel_reg[2];
  assign active    = ~ssel_reg[1];
  assign mosi_bit  = mosi_reg[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sck_reg  <= '0;
      ssel_reg <= '1;
      mosi_reg <= '0;
    end else begin
      sck_reg  <= {sck_reg[1:0], sck};
      ssel_reg <= {ssel_reg[1:0], ssel};
      mosi_reg <= {mosi_reg[0], mosi};
    end
  end

  always_comb begin
    bit_cnt_next       = bit_cnt_reg;
    rx_next            = rx_reg;
    tx_next            = tx_reg;
    received_data_next = received_data_reg;
    byte_received_next = 1'b0;
    data_needed_next   = 1'b0;

    // A deselected (or just-deselected) bus discards any partial word, even on a coincident sck edge.
    if (!active) begin
      bit_cnt_next = '0;
      rx_next      = '0;
    end else if (sck_rise) begin
      rx_next = {rx_reg[WIDTH-2:0], mosi_bit};
      if (bit_cnt_reg == LAST_BIT) begin
        bit_cnt_next       = '0;
        received_data_next = {rx_reg[WIDTH-2:0], mosi_bit};
        byte_received_next = 1'b1;
        data_needed_next   = 1'b1;
      end else begin
        bit_cnt_next = bit_cnt_reg + CW'(1);
      end
    end

    if (ssel_fall) begin
      data_needed_next = 1'b1;
    end

    // Falling edges at count 0 are skipped so a freshly loaded MSB stays on miso for the first rising edge.
    if (data_needed_reg) begin
      tx_next = data_to_send;
    end else if (active && sck_fall && (bit_cnt_reg != '0)) begin
      tx_next = {tx_reg[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_reg       <= '0;
      rx_reg            <= '0;
      tx_reg            <= '0;
      received_data_reg <= '0;
      byte_received_reg <= 1'b0;
      data_needed_reg   <= 1'b0;
    end else begin
      bit_cnt_reg       <= bit_cnt_next;
      rx_reg            <= rx_next;
      tx_reg            <= tx_next;
      received_data_reg <= received_data_next;
      byte_received_reg <= byte_received_next;
      data_needed_reg   <= data_needed_next;
    end
  end

  assign byte_received = byte_received_reg;
  assign received_data = received_data_reg;
  assign data_needed   = data_needed_reg;

`ifdef MISO_TRISTATE_EN
  assign miso = (reset || !active) ? 1'bz : tx_reg[WIDTH-1];
`else
  assign miso = (reset || !active) ? 1'b0 : tx_reg[WIDTH-1];
`endif

endmodule

// File: tb/tb_spi_slave_if.sv
// Randomized SPI-master bench for spi_slave_if with a word-level reference model and per-cycle monitor.
module tb_spi_slave_if;

  localparam int HALF = 8;
`ifdef MISO_TRISTATE_EN
  localparam logic IDLE_MISO = 1'bz;
`else
  localparam logic IDLE_MISO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       sck;
  logic       mosi;
  logic       miso;
  logic       ssel;
  logic       byte_received;
  logic [7:0] received_data;
  logic       data_needed;
  logic [7:0] data_to_send;

  always #5 clk = ~clk;

  spi_slave_if #(.WIDTH(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .sck           (sck),
    .mosi          (mosi),
    .miso          (miso),
    .ssel          (ssel),
    .byte_received (byte_received),
    .received_data (received_data),
    .data_needed   (data_needed),
    .data_to_send  (data_to_send)
  );

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int last_rise = 0;
  int dn_cnt   = 0;
  int br_cnt   = 0;
  int dn_base  = 0;
  int br_base  = 0;
  int mon_idx  = 0;
  bit idle_chk = 1'b0;
  logic [7:0] mosi_plan [5];
  logic [7:0] tx_plan [5];
  logic [7:0] exp_rx [$];
  logic [7:0] exp_word;
  logic [7:0] rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Master clocks nbits of word out MSB first; samples miso on each sck rising edge.
  task automatic xfer(input logic [7:0] word, input int nbits, output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = word[7-i];
      repeat (HALF) @(negedge clk);
      got = {got[6:0], miso};
      sck = 1'b1;
      last_rise = cyc;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic run_frame(input int nwords, input int partial_bits);
    logic [7:0] got;
    dn_base = dn_cnt;
    br_base = br_cnt;
    ssel = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int w = 0; w < nwords; w++) begin
      exp_rx.push_back(mosi_plan[w]);
      xfer(mosi_plan[w], 8, got);
      check("miso_word", {24'h0, got}, {24'h0, tx_plan[w]});
      $display("word %0d: mosi=%02h miso_read=%02h expected_miso=%02h", w, mosi_plan[w], got, tx_plan[w]);
    end
    if (partial_bits > 0) xfer(mosi_plan[nwords], partial_bits, got);
    repeat (HALF) @(negedge clk);
    ssel = 1'b1;
    repeat (8) @(negedge clk);
    check("byte_received_count", br_cnt - br_base, nwords);
    check("data_needed_count", dn_cnt - dn_base, nwords + 1);
    check("missing_words", exp_rx.size(), 0);
  endtask

  initial begin
    int nw;
    int pb;
    reset = 1'b1;
    sck = 1'b0;
    mosi = 1'b0;
    ssel = 1'b1;
    data_to_send = 8'h00;
    for (int i = 0; i < 5; i++) begin
      mosi_plan[i] = 8'h00;
      tx_plan[i] = 8'h00;
    end

    fork
      forever begin
        @(posedge clk);
        cyc++;
      end
      forever begin
        @(negedge clk);
        if (byte_received) begin
          br_cnt++;
          if (exp_rx.size() == 0) begin
            check("unexpected_byte_received", 32'd1, 32'd0);
          end else begin
            exp_word = exp_rx.pop_front();
            check("received_data", {24'h0, received_data}, {24'h0, exp_word});
          end
          check("strobe_latency_le4", {31'h0, (cyc - last_rise) <= 4}, 32'd1);
        end
        if (data_needed) begin
          mon_idx = dn_cnt - dn_base;
          data_to_send = (mon_idx < 5) ? tx_plan[mon_idx] : 8'($urandom);
          dn_cnt++;
        end
        if (idle_chk) begin
          check("idle_byte_received", {31'h0, byte_received}, 32'd0);
          check("idle_data_needed", {31'h0, data_needed}, 32'd0);
          check("idle_miso", {31'h0, miso}, {31'h0, IDLE_MISO});
        end
      end
    join_none

    repeat (4) @(negedge clk);
    check("reset_miso", {31'h0, miso}, {31'h0, IDLE_MISO});
    reset = 1'b0;
    @(negedge clk);
    check("reset_received_data", {24'h0, received_data}, 32'h00);
    check("reset_byte_received", {31'h0, byte_received}, 32'd0);
    check("reset_data_needed", {31'h0, data_needed}, 32'd0);

    // Idle bus with sck toggling: nothing may happen.
    idle_chk = 1'b1;
    for (int i = 0; i < 32; i++) begin
      mosi = 1'($urandom);
      repeat (4) @(negedge clk);
      sck = ~sck;
    end
    sck = 1'b0;
    repeat (4) @(negedge clk);
    idle_chk = 1'b0;
    check("idle_received_data", {24'h0, received_data}, 32'h00);
    $display("idle phase done");

    // Two back-to-back words in one frame.
    mosi_plan[0] = 8'hFF; tx_plan[0] = 8'hFF;
    mosi_plan[1] = 8'h00; tx_plan[1] = 8'h00;
    tx_plan[2] = 8'h96;
    run_frame(2, 0);
    check("lit_received_00", {24'h0, received_data}, 32'h00);

    mosi_plan[0] = 8'hA5; tx_plan[0] = 8'h3C; tx_plan[1] = 8'h11;
    run_frame(1, 0);
    check("lit_received_A5", {24'h0, received_data}, 32'hA5);

    // Frame aborted after 5 bits, then a full frame.
    mosi_plan[0] = 8'hB7; tx_plan[0] = 8'h42;
    run_frame(0, 5);
    check("partial_keeps_A5", {24'h0, received_data}, 32'hA5);
    mosi_plan[0] = 8'h81; tx_plan[0] = 8'hC3; tx_plan[1] = 8'h00;
    run_frame(1, 0);
    check("lit_received_81", {24'h0, received_data}, 32'h81);

    // Reset after 3 bits of 0xF0.
    tx_plan[0] = 8'hE7;
    dn_base = dn_cnt;
    br_base = br_cnt;
    ssel = 1'b0;
    repeat (HALF) @(negedge clk);
    xfer(8'hF0, 3, rd);
    reset = 1'b1;
    #1;
    check("midframe_reset_miso", {31'h0, miso}, {31'h0, IDLE_MISO});
    @(negedge clk);
    reset = 1'b0;
    ssel = 1'b1;
    repeat (8) @(negedge clk);
    check("reset_frame_no_strobe", br_cnt - br_base, 0);
    check("reset_clears_received", {24'h0, received_data}, 32'h00);
    mosi_plan[0] = 8'h5A; tx_plan[0] = 8'h69;
    run_frame(1, 0);
    check("lit_received_5A", {24'h0, received_data}, 32'h5A);

    // Randomized frames.
    for (int f = 0; f < 10; f++) begin
      nw = $urandom_range(1, 3);
      pb = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 7) : 0;
      for (int i = 0; i < 5; i++) begin
        mosi_plan[i] = 8'($urandom);
        tx_plan[i] = 8'($urandom);
      end
      $display("random frame %0d: words=%0d partial_bits=%0d", f, nw, pb);
      run_frame(nw, pb);
      check("random_last_word", {24'h0, received_data}, {24'h0, mosi_plan[nw-1]});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
